sys_ctrl_core_seq: RTL and testbench



---
 rtl/sys_ctrl_core_seq.sv | 170 +++++++++++++++++
 tb/tb_sys_ctrl_core_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_core_seq.sv
// Per-domain clock/reset sequencer: PLL program, lock wait, clock enable, reset hold, release.
// Optional loss-of-lock monitor enabled by defining SYS_CTRL_LOCK_MON_EN.
module sys_ctrl_core_seq #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT    = 1024,
    parameter int unsigned DRAIN_CYCLES    = 4,
    parameter logic [11:0] FB_DIV_RST      = 12'd32,
    parameter logic [3:0]  REF_DIV_RST     = 4'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_req_i,
    input  logic        rst_n_req_i,
    input  logic        pll_cfg_wr_i,
    input  logic [15:0] pll_cfg_i,
    input  logic [31:0] boot_addr_i,
    input  logic [31:0] hartid_i,
    input  logic        pll_locked_i,
    output logic        core_clk_en_o,
    output logic        core_rst_n_o,
    output logic [11:0] pll_fb_div_o,
    output logic [3:0]  pll_ref_div_o,
    output logic        pll_update_o,
    output logic [31:0] boot_addr_o,
    output logic [31:0] hartid_o,
    output logic        locked_o,
    output logic        busy_o,
    output logic        cfg_rej_o,
    output logic        timeout_o,
    output logic        lock_lost_o
);

    localparam int unsigned CNT_MAX_A = (LOCK_TIMEOUT > RST_HOLD_CYCLES) ? LOCK_TIMEOUT : RST_HOLD_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > DRAIN_CYCLES) ? CNT_MAX_A : DRAIN_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        OFF,
        LOCK_WAIT,
        RST_HOLD,
        READY,
        RUN,
        DRAIN,
        FAULT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;
    logic             timeout_set;
    logic             cfg_ok;

    assign locked_o = lock_s;

    assign cfg_ok = pll_cfg_wr_i && (state == OFF || state == FAULT)
                    && (pll_cfg_i[15:4] != '0) && (pll_cfg_i[3:0] != '0);

`ifdef SYS_CTRL_LOCK_MON_EN
    logic lost_set;
`endif

    always_comb begin
        state_nxt   = state;
        timeout_set = 1'b0;
        unique case (state)
            OFF:       if (clk_en_req_i) state_nxt = LOCK_WAIT;
            LOCK_WAIT: begin
                if (!clk_en_req_i)          state_nxt = OFF;
                else if (lock_s)            state_nxt = RST_HOLD;
                else if (cnt == LOCK_LAST) begin
                    state_nxt   = FAULT;
                    timeout_set = 1'b1;
                end
            end
            RST_HOLD: begin
                if (!clk_en_req_i)          state_nxt = DRAIN;
                else if (cnt == HOLD_LAST)  state_nxt = READY;
            end
            READY: begin
                if (!clk_en_req_i)          state_nxt = DRAIN;
                else if (rst_n_req_i)       state_nxt = RUN;
            end
            RUN: begin
                if (!clk_en_req_i)          state_nxt = DRAIN;
                else if (!rst_n_req_i)      state_nxt = RST_HOLD;
            end
            DRAIN:     if (cnt == DRAIN_LAST) state_nxt = OFF;
            FAULT:     if (!clk_en_req_i)   state_nxt = OFF;
            default:                        state_nxt = OFF;
        endcase
`ifdef SYS_CTRL_LOCK_MON_EN
        // Lost lock overrides any request: gate and reset at once, skipping drain.
        lost_set = 1'b0;
        if ((state == RST_HOLD || state == READY || state == RUN) && !lock_s) begin
            state_nxt = FAULT;
            lost_set  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= OFF;
            cnt           <= '0;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            core_clk_en_o <= 1'b0;
            core_rst_n_o  <= 1'b0;
            busy_o        <= 1'b0;
            pll_fb_div_o  <= FB_DIV_RST;
            pll_ref_div_o <= REF_DIV_RST;
            pll_update_o  <= 1'b0;
            cfg_rej_o     <= 1'b0;
            boot_addr_o   <= '0;
            hartid_o      <= '0;
            timeout_o     <= 1'b0;
        end else begin
            lock_meta <= pll_locked_i;
            lock_s    <= lock_meta;
            state     <= state_nxt;

            // Counter restarts on every state change so each state times its own dwell.
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);

            core_clk_en_o <= state_nxt inside {RST_HOLD, READY, RUN, DRAIN};
            core_rst_n_o  <= (state_nxt == RUN);
            busy_o        <= state_nxt inside {LOCK_WAIT, RST_HOLD, DRAIN};

            if (state == OFF && state_nxt == LOCK_WAIT)
                timeout_o <= 1'b0;
            else if (timeout_set)
                timeout_o <= 1'b1;

            pll_update_o <= cfg_ok;
            cfg_rej_o    <= pll_cfg_wr_i && !cfg_ok;
            if (cfg_ok) begin
                pll_fb_div_o  <= pll_cfg_i[15:4];
                pll_ref_div_o <= pll_cfg_i[3:0];
            end

            if (state == READY && state_nxt == RUN) begin
                boot_addr_o <= boot_addr_i;
                hartid_o    <= hartid_i;
            end
        end
    end

`ifdef SYS_CTRL_LOCK_MON_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            lock_lost_o <= 1'b0;
        else if (state == OFF && state_nxt == LOCK_WAIT)
            lock_lost_o <= 1'b0;
        else if (lost_set)
            lock_lost_o <= 1'b1;
    end
`else
    assign lock_lost_o = 1'b0;
`endif

endmodule

// File: tb/tb_sys_ctrl_core_seq.sv
// Bench for sys_ctrl_core_seq: phase/age behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sys_ctrl_core_seq;

    localparam int HOLD = 16;
    localparam int TMO  = 1024;
    localparam int DRN  = 4;

    localparam int P_OFF = 0, P_WAIT = 1, P_HOLD = 2, P_READY = 3, P_RUN = 4, P_DRAIN = 5, P_FAULT = 6;

    logic        clk = 1'b0;
    logic        rst, clk_en_req, rst_n_req, pll_cfg_wr, pll_locked;
    logic [15:0] pll_cfg;
    logic [31:0] boot_addr, hartid;

    logic        core_clk_en, core_rst_n, pll_update, locked, busy, cfg_rej, timeout, lock_lost;
    logic [11:0] fb_div;
    logic [3:0]  ref_div;
    logic [31:0] boot_addr_q, hartid_q;

    always #5 clk = ~clk;

    sys_ctrl_core_seq #(
        .RST_HOLD_CYCLES(HOLD),
        .LOCK_TIMEOUT(TMO),
        .DRAIN_CYCLES(DRN),
        .FB_DIV_RST(12'd32),
        .REF_DIV_RST(4'd1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .clk_en_req_i(clk_en_req),
        .rst_n_req_i(rst_n_req),
        .pll_cfg_wr_i(pll_cfg_wr),
        .pll_cfg_i(pll_cfg),
        .boot_addr_i(boot_addr),
        .hartid_i(hartid),
        .pll_locked_i(pll_locked),
        .core_clk_en_o(core_clk_en),
        .core_rst_n_o(core_rst_n),
        .pll_fb_div_o(fb_div),
        .pll_ref_div_o(ref_div),
        .pll_update_o(pll_update),
        .boot_addr_o(boot_addr_q),
        .hartid_o(hartid_q),
        .locked_o(locked),
        .busy_o(busy),
        .cfg_rej_o(cfg_rej),
        .timeout_o(timeout),
        .lock_lost_o(lock_lost)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus cycles spent in it, lock delay line, register copies.
    int          m_ph = P_OFF;
    int          m_age = 0;
    bit          m_s1 = 0, m_s2 = 0;
    bit          m_to = 0, m_ll = 0, m_upd = 0, m_rej = 0;
    logic [11:0] m_fb = 12'd32;
    logic [3:0]  m_ref = 4'd1;
    logic [31:0] m_boot = 0, m_hart = 0;

    always @(posedge clk) begin : model
        int ph_n;
        bit to_n, ll_n, acc;
        if (rst) begin
            m_ph <= P_OFF; m_age <= 0; m_s1 <= 0; m_s2 <= 0;
            m_to <= 0; m_ll <= 0; m_upd <= 0; m_rej <= 0;
            m_fb <= 12'd32; m_ref <= 4'd1; m_boot <= 0; m_hart <= 0;
        end else begin
            ph_n = m_ph; to_n = m_to; ll_n = m_ll;
            acc = pll_cfg_wr && (m_ph == P_OFF || m_ph == P_FAULT)
                  && (pll_cfg[15:4] != 0) && (pll_cfg[3:0] != 0);
            if (m_ph == P_OFF) begin
                if (clk_en_req) begin ph_n = P_WAIT; to_n = 0; ll_n = 0; end
            end else if (m_ph == P_WAIT) begin
                if (!clk_en_req) ph_n = P_OFF;
                else if (m_s2) ph_n = P_HOLD;
                else if (m_age + 1 >= TMO) begin ph_n = P_FAULT; to_n = 1; end
            end else if (m_ph == P_DRAIN) begin
                if (m_age + 1 >= DRN) ph_n = P_OFF;
            end else if (m_ph == P_FAULT) begin
                if (!clk_en_req) ph_n = P_OFF;
            end else if (!clk_en_req) begin
                ph_n = P_DRAIN;
            end else if (m_ph == P_HOLD) begin
                if (m_age + 1 >= HOLD) ph_n = P_READY;
            end else if (m_ph == P_READY) begin
                if (rst_n_req) ph_n = P_RUN;
            end else if (!rst_n_req) begin
                ph_n = P_HOLD;
            end
`ifdef SYS_CTRL_LOCK_MON_EN
            if ((m_ph == P_HOLD || m_ph == P_READY || m_ph == P_RUN) && !m_s2) begin
                ph_n = P_FAULT; ll_n = 1;
            end
`endif
            if (m_ph == P_READY && ph_n == P_RUN) begin
                m_boot <= boot_addr; m_hart <= hartid;
            end
            if (acc) begin m_fb <= pll_cfg[15:4]; m_ref <= pll_cfg[3:0]; end
            m_upd <= acc;
            m_rej <= pll_cfg_wr && !acc;
            m_ph  <= ph_n;
            m_age <= (ph_n != m_ph) ? 0 : m_age + 1;
            m_to  <= to_n;
            m_ll  <= ll_n;
            m_s1  <= pll_locked;
            m_s2  <= m_s1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_clk_en",  32'(core_clk_en), 32'(m_ph == P_HOLD || m_ph == P_READY || m_ph == P_RUN || m_ph == P_DRAIN));
            check("m_rst_n",   32'(core_rst_n),  32'(m_ph == P_RUN));
            check("m_busy",    32'(busy),        32'(m_ph == P_WAIT || m_ph == P_HOLD || m_ph == P_DRAIN));
            check("m_locked",  32'(locked),      32'(m_s2));
            check("m_fb_div",  32'(fb_div),      32'(m_fb));
            check("m_ref_div", 32'(ref_div),     32'(m_ref));
            check("m_update",  32'(pll_update),  32'(m_upd));
            check("m_cfg_rej", 32'(cfg_rej),     32'(m_rej));
            check("m_timeout", 32'(timeout),     32'(m_to));
            check("m_lock_lost", 32'(lock_lost), 32'(m_ll));
            check("m_boot",    boot_addr_q,      m_boot);
            check("m_hartid",  hartid_q,         m_hart);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; clk_en_req = 0; rst_n_req = 0; pll_cfg_wr = 0; pll_cfg = 0;
        pll_locked = 1; boot_addr = 0; hartid = 0;
        @(posedge clk);
        chk_en = 1;
        #1;
        check("rst_clk_en", 32'(core_clk_en), 0);
        check("rst_rst_n",  32'(core_rst_n), 0);
        check("rst_fb_div", 32'(fb_div), 32);
        check("rst_ref_div", 32'(ref_div), 1);
        check("rst_locked", 32'(locked), 0);
        tick(2);
        rst = 0;
        tick(3);
        check("lock_sync", 32'(locked), 1);

        // Bring-up: cycle 0 request
        boot_addr = 32'h8000_0000; hartid = 3; clk_en_req = 1;
        tick(1);  check("bu_c1_busy", 32'(busy), 1);  check("bu_c1_clk_en", 32'(core_clk_en), 0);
        tick(1);  check("bu_c2_clk_en", 32'(core_clk_en), 1);
        tick(15); check("bu_c17_busy", 32'(busy), 1);
        tick(1);  check("bu_c18_ready", 32'(busy), 0); check("bu_c18_rst_n", 32'(core_rst_n), 0);
        tick(2);  rst_n_req = 1;
        tick(1);  check("bu_c21_rst_n", 32'(core_rst_n), 1);
        check("bu_boot", boot_addr_q, 32'h8000_0000);
        check("bu_hartid", hartid_q, 3);
        boot_addr = 32'h0000_1234; hartid = 7;
        tick(2);  check("bu_boot_hold", boot_addr_q, 32'h8000_0000);

        // PLL write while running is rejected
        pll_cfg = {12'd50, 4'd2}; pll_cfg_wr = 1;
        tick(1); pll_cfg_wr = 0;
        check("run_wr_rej", 32'(cfg_rej), 1); check("run_wr_fb", 32'(fb_div), 32);
        tick(1); check("run_rej_pulse", 32'(cfg_rej), 0);

        // Reset re-pulse: full hold re-applied
        rst_n_req = 0;
        tick(1); check("rp_rst_n", 32'(core_rst_n), 0); check("rp_clk_en", 32'(core_clk_en), 1);
        rst_n_req = 1;
        tick(15); check("rp_hold16", 32'(busy), 1); check("rp_hold16_rst_n", 32'(core_rst_n), 0);
        tick(1);  check("rp_ready", 32'(busy), 0); check("rp_ready_rst_n", 32'(core_rst_n), 0);
        tick(1);  check("rp_run", 32'(core_rst_n), 1);

        // Shutdown through drain
        clk_en_req = 0;
        tick(1); check("sd_rst_n", 32'(core_rst_n), 0); check("sd_clk_en1", 32'(core_clk_en), 1);
        tick(3); check("sd_clk_en4", 32'(core_clk_en), 1);
        tick(1); check("sd_off", 32'(core_clk_en), 0); check("sd_off_busy", 32'(busy), 0);

        // PLL writes in OFF
        pll_cfg = {12'd50, 4'd2}; pll_cfg_wr = 1;
        tick(1); pll_cfg_wr = 0;
        check("off_wr_upd", 32'(pll_update), 1); check("off_wr_fb", 32'(fb_div), 50); check("off_wr_ref", 32'(ref_div), 2);
        tick(1); check("off_upd_pulse", 32'(pll_update), 0);
        pll_cfg = {12'd60, 4'd0}; pll_cfg_wr = 1;
        tick(1); pll_cfg_wr = 0;
        check("ref0_rej", 32'(cfg_rej), 1); check("ref0_fb", 32'(fb_div), 50);
        pll_cfg = {12'd0, 4'd5}; pll_cfg_wr = 1;
        tick(1); pll_cfg_wr = 0;
        check("fb0_rej", 32'(cfg_rej), 1); check("fb0_ref", 32'(ref_div), 2);

        // Write coincident with OFF->LOCK_WAIT
        rst_n_req = 0; pll_cfg = {12'd40, 4'd3}; pll_cfg_wr = 1; clk_en_req = 1;
        tick(1); pll_cfg_wr = 0;
        check("co_fb", 32'(fb_div), 40); check("co_ref", 32'(ref_div), 3); check("co_busy", 32'(busy), 1);
        tick(17); rst_n_req = 1;
        tick(1); check("co_run", 32'(core_rst_n), 1);

        // Both requests dropped together: drain, not hold
        clk_en_req = 0; rst_n_req = 0;
        tick(1); check("both_busy", 32'(busy), 1); check("both_rst_n", 32'(core_rst_n), 0);
        tick(4); check("both_off", 32'(core_clk_en), 0);

        // Lock timeout
        pll_locked = 0;
        tick(3); check("lk_low", 32'(locked), 0);
        clk_en_req = 1;
        tick(1);    check("to_c1_busy", 32'(busy), 1);
        tick(1023); check("to_c1024_busy", 32'(busy), 1); check("to_c1024_flag", 32'(timeout), 0);
        tick(1);    check("to_fault_flag", 32'(timeout), 1); check("to_fault_clk", 32'(core_clk_en), 0);
        check("to_fault_busy", 32'(busy), 0);
        pll_cfg = {12'd64, 4'd4}; pll_cfg_wr = 1;
        tick(1); pll_cfg_wr = 0;
        check("fault_wr_upd", 32'(pll_update), 1); check("fault_wr_fb", 32'(fb_div), 64);
        clk_en_req = 0;
        tick(1); check("to_off_sticky", 32'(timeout), 1);
        clk_en_req = 1;
        tick(1); check("to_cleared", 32'(timeout), 0);

        // rst_i mid-RST_HOLD
        pll_locked = 1;
        tick(5); check("mid_hold_clk", 32'(core_clk_en), 1); check("mid_hold_busy", 32'(busy), 1);
        rst = 1;
        tick(1);
        check("mr_clk_en", 32'(core_clk_en), 0); check("mr_busy", 32'(busy), 0);
        check("mr_fb", 32'(fb_div), 32); check("mr_ref", 32'(ref_div), 1);
        check("mr_locked", 32'(locked), 0); check("mr_boot", boot_addr_q, 0);
        rst = 0; clk_en_req = 0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
